// File: rtl/mips_cpu_bus_mem_port.sv
// Load/store port: turns one CPU byte/half/word access into a single aligned Avalon-style bus
// transfer and returns lane-extracted read data. Optional macro: MEMPORT_TIMEOUT_EN.
module mips_cpu_bus_mem_port #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // CPU side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  // Bus side
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBus    = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [1:0] LatLast = 2'(READ_LATENCY);

  logic [1:0]  state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  lat_q, lat_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

`ifdef MEMPORT_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q, wait_d;
`endif

  logic [1:0]  req_off;
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lanes;
  logic [31:0] rdata_ext;

  assign req_off = req_addr[1:0];

  always_comb begin
    req_misaligned  = 1'b0;
    req_be          = 4'b1111;
    req_wdata_lanes = req_wdata;
    unique case (req_size)
      2'b00: begin
        req_be          = 4'b0001 << req_off;
        req_wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned  = req_off[0];
        req_be          = req_off[1] ? 4'b1100 : 4'b0011;
        req_wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_misaligned  = (req_off != 2'b00);
      end
      default: begin
        req_misaligned  = 1'b1;
      end
    endcase
  end

  // Lane extraction uses the offset/size/sign latched at request acceptance.
  function automatic logic [31:0] extract(input logic [31:0] data, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = data >> {off, 3'b000};
    case (size)
      2'b00:   res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      2'b01:   res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign rdata_ext = extract(readdata, size_q, signed_q, off_q);

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    lat_d        = lat_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
`ifdef MEMPORT_TIMEOUT_EN
    wait_d       = wait_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d  = StBus;
            read_d   = ~req_write;
            write_d  = req_write;
            addr_d   = {req_addr[31:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_write ? req_wdata_lanes : 32'h0;
            size_d   = req_size;
            signed_d = req_signed;
            off_d    = req_off;
`ifdef MEMPORT_TIMEOUT_EN
            wait_d   = 8'd0;
`endif
          end
        end
      end

      StBus: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
          end else if (READ_LATENCY == 0) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = rdata_ext;
          end else begin
            state_d = StRdWait;
            lat_d   = 2'd1;
          end
        end
`ifdef MEMPORT_TIMEOUT_EN
        // Abort after TIMEOUT_CYCLES consecutive stalled cycles.
        else if (wait_q == TimeoutLast) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end

      StRdWait: begin
        if (lat_q == LatLast) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = rdata_ext;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= 4'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      lat_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
`ifdef MEMPORT_TIMEOUT_EN
      wait_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MEMPORT_TIMEOUT_EN
      wait_q       <= wait_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = addr_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_mem_port.sv
// Directed bench for mips_cpu_bus_mem_port: small bus memory with programmable stall,
// READ_LATENCY=1, TIMEOUT_CYCLES=4 (used only when MEMPORT_TIMEOUT_EN is defined).
module tb_mips_cpu_bus_mem_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int n_checks = 0;
  int n_errors = 0;

  mips_cpu_bus_mem_port #(
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  // Bus memory: stall count reloads while idle, read data valid one cycle after acceptance.
  logic [31:0] mem [0:15];
  logic [31:0] rd_pipe;
  int          stall_req = 0;
  int          stall_cnt;

  assign waitrequest = (read || write) && (stall_cnt != 0);
  assign readdata    = rd_pipe;

  always @(posedge clk) begin
    if (!(read || write)) stall_cnt <= stall_req;
    else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    if (write && !waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
    end
    if (read && !waitrequest) rd_pipe <= mem[address[5:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          r_lat, r_strobes;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_err, r_stable;

  task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int stall);
    int n;
    stall_req = stall;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    // Junk on req_* after the accept edge must be ignored.
    req_valid = 1'b0; req_write = ~wr; req_size = 2'b10; req_signed = ~sg;
    req_addr = 32'hffff_fff3; req_wdata = 32'h5a5a_5a5a;
    n = 1; r_strobes = 0; r_stable = 1'b1; r_addr = 0; r_be = 0; r_wdata = 0;
    while (!resp_valid && n < 60) begin
      if (read || write) begin
        if (r_strobes == 0) begin
          r_addr = address; r_be = byteenable; r_wdata = writedata;
        end else if (address !== r_addr || byteenable !== r_be || writedata !== r_wdata) begin
          r_stable = 1'b0;
        end
        if (read && write) r_stable = 1'b0;
        r_strobes++;
      end
      @(negedge clk);
      n++;
    end
    r_lat = n; r_rdata = resp_rdata; r_err = resp_err;
    check_eq("resp_seen", 32'(resp_valid), 32'd1);
    check_eq("strobe_low_in_resp", 32'(read | write), 32'd0);
    check_eq("ready_low_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
    check_eq("resp_rdata_cleared", resp_rdata, 32'h0);
  endtask

  task automatic check_resp(input string tag, input int lat, input logic [31:0] rdata,
                            input logic err, input int strobes);
    check_eq({tag, "_lat"}, r_lat, lat);
    check_eq({tag, "_rdata"}, r_rdata, rdata);
    check_eq({tag, "_err"}, 32'(r_err), 32'(err));
    check_eq({tag, "_strobes"}, r_strobes, strobes);
    check_eq({tag, "_stable"}, 32'(r_stable), 32'd1);
  endtask

  task automatic check_bus(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
    check_eq({tag, "_addr"}, r_addr, a);
    check_eq({tag, "_be"}, 32'(r_be), 32'(be));
    check_eq({tag, "_wdata"}, r_wdata, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    check_eq("rst_read", 32'(read), 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_be", 32'(byteenable), 32'd0);
    check_eq("rst_address", address, 32'h0);
    check_eq("rst_writedata", writedata, 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);

    // Word store then load.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h8bad_f00d, 0);
    check_resp("sw10", 2, 32'h0, 1'b0, 1);
    check_bus("sw10", 32'h10, 4'b1111, 32'h8bad_f00d);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_resp("lw10", 3, 32'h8bad_f00d, 1'b0, 1);
    check_bus("lw10", 32'h10, 4'b1111, 32'h0);

    // Byte 0x80 into lane 3; word at 0x10 becomes 0x80adf00d.
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0);
    check_resp("sb13", 2, 32'h0, 1'b0, 1);
    check_bus("sb13", 32'h10, 4'b1000, 32'h8080_8080);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    check_resp("lb13", 3, 32'hffff_ff80, 1'b0, 1);
    check_eq("lb13_be", 32'(r_be), 32'h8);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    check_resp("lbu13", 3, 32'h0000_0080, 1'b0, 1);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    check_resp("lb11", 3, 32'hffff_fff0, 1'b0, 1);
    check_eq("lb11_be", 32'(r_be), 32'h2);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    check_resp("lh12", 3, 32'hffff_80ad, 1'b0, 1);
    check_eq("lh12_be", 32'(r_be), 32'hc);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
    check_resp("lhu10", 3, 32'h0000_f00d, 1'b0, 1);
    check_eq("lhu10_be", 32'(r_be), 32'h3);
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 0);
    check_resp("lw10s", 3, 32'h80ad_f00d, 1'b0, 1);

    // Halfword store held by three waitrequest cycles, then stalled read.
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_abcd, 3);
    check_resp("sh22", 5, 32'h0, 1'b0, 4);
    check_bus("sh22", 32'h20, 4'b1100, 32'habcd_abcd);
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 2);
    check_resp("lhu22", 5, 32'h0000_abcd, 1'b0, 3);

    // Misaligned and illegal requests: no bus cycle.
    access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
    check_resp("lw11", 1, 32'h0, 1'b1, 0);
    access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 0);
    check_resp("lh13", 1, 32'h0, 1'b1, 0);
    access(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    check_resp("size11", 1, 32'h0, 1'b1, 0);

`ifdef MEMPORT_TIMEOUT_EN
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h1111_2222, 1000);
    check_resp("timeout", 5, 32'h0, 1'b1, 4);
`else
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h1111_2222, 20);
    check_resp("longwait", 22, 32'h0, 1'b0, 21);
`endif

    // Reset while a store is held by waitrequest.
    stall_req = 100;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h34;
    req_wdata = 32'hcafe_babe;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("held_write", 32'(write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("midrst_write", 32'(write), 32'd0);
    check_eq("midrst_be", 32'(byteenable), 32'd0);
    stall_req = 0;
    @(negedge clk);
    check_eq("midrst_resp", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_noresp", 32'(resp_valid), 32'd0);

    // Port still usable after the abandoned store.
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_resp("lw_after_rst", 3, 32'h80ad_f00d, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
